// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared types and geometry of the 64-line direct-mapped,
//            128-bit-block cache controlled by cache_controller.
// Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Cache geometry
  localparam int BLOCKS     = 64;
  localparam int WORDS      = 4;
  localparam int WORD_SIZE  = 32;
  localparam int BLOCK_SIZE = 128;

  // Controller FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    ALLOCATE  = 3'd3,
    REFILL    = 3'd4,
    DONE      = 3'd5,
    ERR       = 3'd6
  } cc_state_t;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_stat_counter.sv
`default_nettype none
// ============================================================================
// Module   : cache_stat_counter
// Brief    : Saturating statistics counter; sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module cache_stat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count increments until the counter is full, then hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule : cache_stat_counter
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_controller
// Brief    : Main FSM of the direct-mapped cache. Sequences hit check,
//            dirty writeback, block refill and retry; runs the memory
//            request/ack handshake with timeout; keeps hit/miss statistics.
// Revision : 1.0 - initial release
// ============================================================================
module cache_controller
  import cache_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  // CPU side
  input  logic             cpu_valid,
  input  logic             cpu_req_type,
  output logic             cpu_done,
  output logic             cpu_err,
  output logic             cpu_busy,
  // Datapath side
  input  logic             hit,
  input  logic             dirty_bit,
  output logic             req_type,
  output logic             read_en_cache,
  output logic             write_en_cache,
  output logic             refill,
  // Memory side
  output logic             mem_read_req,
  output logic             mem_write_req,
  input  logic             mem_ack,
  // Statistics
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  // Wait counter only has to represent 0 .. MEM_TIMEOUT-1
  localparam int              TO_W      = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [TO_W-1:0] c_to_last = TO_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam bit              c_to_en   = (MEM_TIMEOUT > 0);

  cc_state_t       r_state;
  logic            r_req_type;
  logic            r_first;
  logic [TO_W-1:0] r_to_cnt;

  logic            w_timeout;
  logic            w_hit_inc;
  logic            w_miss_inc;

  // The last permitted waiting cycle has been used up
  assign w_timeout  = c_to_en && (r_to_cnt == c_to_last);

  // Only the first compare of a request is a statistic; the retry after refill is not
  assign w_hit_inc  = (r_state == COMPARE) && r_first && hit;
  assign w_miss_inc = (r_state == COMPARE) && r_first && !hit;

  // Controller FSM with inline memory-wait timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_req_type <= 1'b0;
      r_first    <= 1'b0;
      r_to_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_valid) begin
            r_req_type <= cpu_req_type;
            r_first    <= 1'b1;
            r_state    <= COMPARE;
          end
        end
        COMPARE: begin
          r_first <= 1'b0;
          if (hit) begin
            r_state <= DONE;
          end else begin
            r_to_cnt <= '0;
            r_state  <= dirty_bit ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          // An ack in the timeout cycle still completes the transfer
          if (mem_ack) begin
            r_to_cnt <= '0;
            r_state  <= ALLOCATE;
          end else if (w_timeout) begin
            r_state <= ERR;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ALLOCATE: begin
          if (mem_ack) begin
            r_state <= REFILL;
          end else if (w_timeout) begin
            r_state <= ERR;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        REFILL:  r_state <= COMPARE;
        DONE:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output decode from the registered state. Write enable in COMPARE also
  // qualifies on the datapath tag match so a write hit lands in the same
  // cycle it is detected, without an extra state.
  assign cpu_busy       = (r_state != IDLE);
  assign cpu_done       = (r_state == DONE) || (r_state == ERR);
  assign cpu_err        = (r_state == ERR);
  assign req_type       = r_req_type;
  assign read_en_cache  = (r_state == COMPARE);
  assign write_en_cache = ((r_state == COMPARE) && r_req_type && hit) || (r_state == REFILL);
  assign refill         = (r_state == REFILL);
  assign mem_write_req  = (r_state == WRITEBACK);
  assign mem_read_req   = (r_state == ALLOCATE);

  cache_stat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_hit_inc),
    .o_count (hit_count)
  );

  cache_stat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_miss_inc),
    .o_count (miss_count)
  );

endmodule : cache_controller
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_controller
// Brief    : Self-checking bench for cache_controller. A behavioural cache
//            datapath and backing memory surround the DUT; a flat word
//            memory is the golden reference for data returned to the CPU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int MAXD = 5;
  localparam int SATV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_valid = 1'b0;
  logic          cpu_req_type = 1'b0;
  logic          cpu_done, cpu_err, cpu_busy;
  logic          hit, dirty_bit;
  logic          req_type, read_en_cache, write_en_cache, refill;
  logic          mem_read_req, mem_write_req;
  logic          mem_ack = 1'b0;
  logic [CW-1:0] hit_count, miss_count;

  logic [11:0]   cpu_addr  = '0;
  logic [31:0]   cpu_wdata = '0;
  logic          tb_init   = 1'b1;
  bit            never_ack = 1'b0;

  int total = 0;
  int bad   = 0;
  int ack_waits = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Behavioural datapath and backing memory
  logic [127:0] cdata [64];
  logic [3:0]   ctag  [64];
  logic [63:0]  cvalid, cdirty;
  logic [127:0] bmem  [1024];
  logic [31:0]  gmem  [4096];

  logic [5:0]   a_idx;
  logic [3:0]   a_tag;
  logic [1:0]   a_w;

  assign a_idx     = cpu_addr[7:2];
  assign a_tag     = cpu_addr[11:8];
  assign a_w       = cpu_addr[1:0];
  assign hit       = cvalid[a_idx] && (ctag[a_idx] == a_tag);
  assign dirty_bit = cdirty[a_idx];

  cache_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_valid      (cpu_valid),
    .cpu_req_type   (cpu_req_type),
    .cpu_done       (cpu_done),
    .cpu_err        (cpu_err),
    .cpu_busy       (cpu_busy),
    .hit            (hit),
    .dirty_bit      (dirty_bit),
    .req_type       (req_type),
    .read_en_cache  (read_en_cache),
    .write_en_cache (write_en_cache),
    .refill         (refill),
    .mem_read_req   (mem_read_req),
    .mem_write_req  (mem_write_req),
    .mem_ack        (mem_ack),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] winit(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic int sat(input int v);
    return (v > SATV) ? SATV : v;
  endfunction

  // Datapath: refill, CPU write, and writeback of the evicted block
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++)
        bmem[i] <= {winit(i*4+3), winit(i*4+2), winit(i*4+1), winit(i*4)};
      cvalid <= '0;
      cdirty <= '0;
    end else begin
      if (write_en_cache && refill) begin
        cdata[a_idx]  <= bmem[cpu_addr[11:2]];
        ctag[a_idx]   <= a_tag;
        cvalid[a_idx] <= 1'b1;
        cdirty[a_idx] <= 1'b0;
      end else if (write_en_cache) begin
        cdata[a_idx][{a_w, 5'b0} +: 32] <= cpu_wdata;
        cdirty[a_idx] <= 1'b1;
      end
      if (mem_write_req && mem_ack)
        bmem[{ctag[a_idx], a_idx}] <= cdata[a_idx];
    end
  end

  // Memory responder: random wait per request, ack as a one-cycle pulse
  initial begin
    int rcnt;
    rcnt = -1;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if ((mem_read_req || mem_write_req) && !never_ack) begin
        if (rcnt < 0) begin
          rcnt = int'($urandom_range(0, MAXD));
          ack_waits += rcnt;
        end
        if (rcnt == 0) begin
          mem_ack = 1'b1;
          rcnt = -1;
        end else begin
          rcnt--;
        end
      end else begin
        rcnt = -1;
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // One CPU access; expectations come from the line state before issue
  task automatic do_req(input logic [11:0] addr, input logic we, input logic [31:0] wd,
                        input bit b2b, input bit hold);
    logic [5:0] idx;
    logic [3:0] tg;
    bit h0, d0, wb_seen, got;
    int w0, cyc, refills, lat_exp;
    if (!b2b) @(negedge clk);
    idx = addr[7:2];
    tg  = addr[11:8];
    h0  = cvalid[idx] && (ctag[idx] == tg);
    d0  = cdirty[idx];
    w0  = ack_waits;
    cpu_addr = addr; cpu_req_type = we; cpu_wdata = wd; cpu_valid = 1'b1;
    cyc = b2b ? 0 : 1;
    refills = 0; wb_seen = 1'b0; got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      cyc++;
      if (refill) refills++;
      if (mem_write_req) wb_seen = 1'b1;
      if (cpu_done) got = 1'b1;
    end
    if (!hold) cpu_valid = 1'b0;
    lat_exp = h0 ? 3 : ((d0 ? 7 : 6) + (ack_waits - w0));
    check("done_seen", int'(got), 1);
    check("latency",   cyc, lat_exp);
    check("err",       int'(cpu_err), 0);
    check("refills",   refills, h0 ? 0 : 1);
    check("writeback", int'(wb_seen), int'(!h0 && d0));
    if (h0) exp_hits++; else exp_misses++;
    if (we) gmem[addr] = wd;
    check("data",      int'(cdata[idx][{addr[1:0], 5'b0} +: 32]), int'(gmem[addr]));
    check("dirty",     int'(cdirty[idx]), we ? 1 : (h0 ? int'(d0) : 0));
    check("hit_count", int'(hit_count),  sat(exp_hits));
    check("miss_count",int'(miss_count), sat(exp_misses));
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc, rd_cycles, refills, a;
    bit  got;
    for (int i = 0; i < 4096; i++) gmem[i] = winit(i);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_outs", int'({cpu_done, cpu_err, cpu_busy, req_type, read_en_cache,
                            write_en_cache, refill, mem_read_req, mem_write_req}), 0);
    check("rst_hits", int'(hit_count), 0);
    check("rst_miss", int'(miss_count), 0);
    rst = 1'b0; tb_init = 1'b0;

    // Clean read miss then read hit on the same line
    do_req(12'h104, 1'b0, 32'h0, 1'b0, 1'b0);
    do_req(12'h104, 1'b0, 32'h0, 1'b0, 1'b0);
    check("dir_hit1",  int'(hit_count), 1);
    check("dir_miss1", int'(miss_count), 1);

    // Write miss on clean line, dirty read miss evicting it, re-read evicted data
    do_req(12'h208, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    do_req(12'h308, 1'b0, 32'h0, 1'b0, 1'b0);
    do_req(12'h208, 1'b0, 32'h0, 1'b0, 1'b0);

    // Memory never acks: timeout from ALLOCATE
    never_ack = 1'b1;
    @(negedge clk);
    cpu_addr = 12'h150; cpu_req_type = 1'b0; cpu_valid = 1'b1;
    cyc = 1; rd_cycles = 0; refills = 0; got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      cyc++;
      if (mem_read_req) rd_cycles++;
      if (refill) refills++;
      if (cpu_done) got = 1'b1;
    end
    check("to_done",   int'(got), 1);
    check("to_lat",    cyc, 11);
    check("to_err",    int'(cpu_err), 1);
    check("to_rdcyc",  rd_cycles, TO);
    check("to_refill", refills, 0);
    check("to_line",   int'(cvalid[20]), 0);
    cpu_valid = 1'b0;
    exp_misses++;
    check("to_miss",   int'(miss_count), sat(exp_misses));
    @(negedge clk);
    check("to_idle",   int'({cpu_busy, mem_read_req, cpu_done}), 0);
    never_ack = 1'b0;

    // Reset asserted while in WRITEBACK
    do_req(12'h104, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    never_ack = 1'b1;
    @(negedge clk);
    cpu_addr = 12'h504; cpu_req_type = 1'b0; cpu_valid = 1'b1; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (mem_write_req) got = 1'b1;
    end
    check("rst_wb_reached", int'(got), 1);
    #2;
    rst = 1'b1; cpu_valid = 1'b0;
    #1;
    check("arst_outs", int'({cpu_done, cpu_err, cpu_busy, req_type, read_en_cache,
                             write_en_cache, refill, mem_read_req, mem_write_req}), 0);
    check("arst_hits", int'(hit_count), 0);
    check("arst_miss", int'(miss_count), 0);
    @(negedge clk);
    rst = 1'b0; never_ack = 1'b0;
    exp_hits = 0; exp_misses = 0;
    do_req(12'h504, 1'b0, 32'h0, 1'b0, 1'b0);

    // Back-to-back hits with cpu_valid held high; hit counter saturates
    for (int n = 0; n < 20; n++)
      do_req(12'h504, 1'b0, 32'h0, (n != 0), (n != 19));
    check("sat_hits", int'(hit_count), SATV);

    // Randomized accesses over a small conflicting address set
    for (int n = 0; n < 60; n++) begin
      a = int'($urandom_range(0, 3)) * 256 + int'($urandom_range(0, 3)) * 4
        + int'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(a[11:0], 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cache_controller
`default_nettype wire
